// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter and its priority selector.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StResp
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_OFF_W = $clog2(WORD_BYTES);
  localparam int unsigned STREAK_W   = 4;

endpackage

// File: rtl/arb_prio_select.sv
// Combinational fetch/data priority pick: data wins unless its streak has hit the limit.
module arb_prio_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_i,
  output logic                grant_d
);

  localparam logic [STREAK_W-1:0] MaxStreak = STREAK_W'(MAX_D_STREAK);

  logic streak_at_max;

  always_comb begin
    streak_at_max = (streak == MaxStreak);
    grant_i       = if_req & (~d_req | streak_at_max);
    grant_d       = d_req & ~grant_i;
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Serialises fetch and load/store accesses onto one word memory with a req/done handshake.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam logic [STREAK_W-1:0] MaxStreak = STREAK_W'(MAX_D_STREAK);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                if_done_q, if_done_d;
  logic                if_err_q, if_err_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic                d_done_q, d_done_d;
  logic                d_err_q, d_err_d;
  logic [31:0]         d_rdata_q, d_rdata_d;

  logic              grant_i, grant_d;
  logic              winner;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [31:0]       sel_wdata;
  logic              sel_misaligned;

  arb_prio_select #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_prio (
    .if_req (if_req),
    .d_req  (d_req),
    .streak (streak_q),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

  always_comb begin
    winner         = grant_d ? REQ_D : REQ_I;
    sel_addr       = (winner == REQ_D) ? d_addr : if_addr;
    sel_we         = (winner == REQ_D) & d_we;
    sel_wdata      = (winner == REQ_D) ? d_wdata : '0;
    sel_misaligned = (sel_addr[WORD_OFF_W-1:0] != '0);
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    // Done/err are set only on the edge into StResp, so they pulse for exactly one cycle.
    if_done_d   = 1'b0;
    if_err_d    = 1'b0;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!if_req) begin
          streak_d = '0;
        end
        if (grant_i) begin
          streak_d = '0;
        end else if (grant_d && if_req && (streak_q < MaxStreak)) begin
          streak_d = streak_q + 1'b1;
        end

        if (grant_i || grant_d) begin
          if (sel_misaligned) begin
            state_d = StResp;
            if (winner == REQ_D) begin
              d_done_d  = 1'b1;
              d_err_d   = 1'b1;
              d_rdata_d = '0;
            end else begin
              if_done_d  = 1'b1;
              if_err_d   = 1'b1;
              if_rdata_d = '0;
            end
          end else begin
            state_d     = (winner == REQ_D) ? StBusyD : StBusyI;
            mem_req_d   = 1'b1;
            mem_we_d    = sel_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
          end
        end
      end

      StBusyI: begin
        if (mem_ready) begin
          state_d    = StResp;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = mem_rdata;
          if_done_d  = 1'b1;
        end
      end

      StBusyD: begin
        if (mem_ready) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_rdata_d = mem_we_q ? '0 : mem_rdata;
          d_done_d  = 1'b1;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: vector table plus reset, contention and long-wait sequences.
module tb_imem_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  imem_dmem_arbiter #(
    .ADDR_W      (32),
    .MAX_D_STREAK(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .d_err    (d_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with a programmable number of wait states per access.
  logic [31:0] mem [0:63];
  int          wait_cfg;
  int          wait_cnt    = 0;
  int          writes      = 0;
  int          mreq_cycles = 0;
  logic [31:0] last_addr   = '0;
  int          max_streak  = 0;

  assign mem_ready = mem_req && (wait_cnt >= wait_cfg);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (!mem_req || mem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (mem_req) begin
      mreq_cycles <= mreq_cycles + 1;
      last_addr   <= mem_addr;
    end
    if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      writes             <= writes + 1;
    end
    if (int'(dut.streak_q) > max_streak) max_streak <= int'(dut.streak_q);
  end

  int total  = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passes++;
  endtask

  typedef struct {
    logic        is_f;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_mreq;
    int          exp_wr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, other, wr0, mq0, n, first_c, last_c, unstable, dones;
    logic        got, er, seen;
    logic [31:0] rd, cap_addr, cap_wdata;
    logic        cap_we;
    logic [9:0]  order;

    //           is_f  we    addr   wdata         w  rdata         err  lat mreq wr
    vecs[0] = '{1'b0, 1'b1, 32'h8, 32'h01400113, 0, 32'h0,        1'b0, 2, 1, 1};
    vecs[1] = '{1'b1, 1'b0, 32'h8, 32'h0,        0, 32'h01400113, 1'b0, 2, 1, 0};
    vecs[2] = '{1'b0, 1'b1, 32'h0, 32'd30,       2, 32'h0,        1'b0, 4, 3, 1};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h0,        2, 32'd30,       1'b0, 4, 3, 0};
    vecs[4] = '{1'b0, 1'b0, 32'h6, 32'h0,        0, 32'h0,        1'b1, 1, 0, 0};
    vecs[5] = '{1'b1, 1'b0, 32'h2, 32'h0,        0, 32'h0,        1'b1, 1, 0, 0};
    vecs[6] = '{1'b0, 1'b1, 32'h5, 32'hFF,       0, 32'h0,        1'b1, 1, 0, 0};
    vecs[7] = '{1'b1, 1'b0, 32'h0, 32'h0,        1, 32'd30,       1'b0, 3, 2, 0};

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; wait_cfg = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_zero", 64'(|{mem_req, mem_we, mem_addr, mem_wdata, if_done, d_done,
                                       if_err, d_err, if_rdata, d_rdata}), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", 64'(|{mem_req, if_done, d_done}), 64'd0);

    for (int v = 0; v < 8; v++) begin
      wait_cfg = vecs[v].waits;
      wr0 = writes;
      mq0 = mreq_cycles;
      @(negedge clk);
      if (vecs[v].is_f) begin
        if_addr = vecs[v].addr;
        if_req  = 1'b1;
      end else begin
        d_addr  = vecs[v].addr;
        d_we    = vecs[v].we;
        d_wdata = vecs[v].wdata;
        d_req   = 1'b1;
      end
      lat = -1; other = 0; got = 1'b0; rd = '0; er = 1'b0;
      for (int c = 1; c <= 60 && !got; c++) begin
        @(posedge clk);
        #1;
        if (vecs[v].is_f ? d_done : if_done) other++;
        if (vecs[v].is_f ? if_done : d_done) begin
          got = 1'b1;
          lat = c;
          rd  = vecs[v].is_f ? if_rdata : d_rdata;
          er  = vecs[v].is_f ? if_err : d_err;
        end
      end
      @(negedge clk);
      if_req = 1'b0;
      d_req  = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
      check($sformatf("v%0d_rdata", v), 64'(rd), 64'(vecs[v].exp_rdata));
      check($sformatf("v%0d_err", v), 64'(er), 64'(vecs[v].exp_err));
      check($sformatf("v%0d_other_done", v), 64'(other), 64'd0);
      check($sformatf("v%0d_mem_req_cycles", v), 64'(mreq_cycles - mq0), 64'(vecs[v].exp_mreq));
      check($sformatf("v%0d_writes", v), 64'(writes - wr0), 64'(vecs[v].exp_wr));
      check($sformatf("v%0d_done_single", v), 64'(if_done | d_done), 64'd0);
      if (vecs[v].exp_mreq != 0)
        check($sformatf("v%0d_mem_addr", v), 64'(last_addr), 64'(vecs[v].addr));
    end

    // Contention: both requests held through every done.
    wait_cfg = 0;
    @(negedge clk);
    if_addr = 32'h10; d_addr = 32'h14; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
    order = '0; n = 0; first_c = 0; last_c = 0;
    for (int c = 1; c <= 80 && n < 10; c++) begin
      @(posedge clk);
      #1;
      if (d_done || if_done) begin
        order = {order[8:0], d_done};
        if (n == 0) first_c = c;
        last_c = c;
        n++;
      end
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("contention_count", 64'(n), 64'd10);
    check("contention_order", 64'(order), 64'(10'b1111011110));
    check("contention_spacing", 64'(last_c - first_c), 64'd27);
    check("contention_max_streak", 64'(max_streak), 64'd4);
    check("contention_idle_after", 64'(|{mem_req, if_done, d_done}), 64'd0);

    // Long wait: store stalled for 20 cycles.
    wait_cfg = 20;
    wr0 = writes; mq0 = mreq_cycles;
    @(negedge clk);
    d_addr = 32'h40; d_we = 1'b1; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    seen = 1'b0; unstable = 0; dones = 0; lat = -1;
    cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (!seen) begin
          seen = 1'b1; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
        end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_we !== cap_we) begin
          unstable++;
        end
      end
      if (d_done) begin
        dones++;
        if (lat < 0) lat = c;
        @(negedge clk);
        d_req = 1'b0;
      end
    end
    check("longwait_stable", 64'(unstable), 64'd0);
    check("longwait_latched", 64'({cap_we, cap_addr, cap_wdata}), {31'd0, 1'b1, 32'h40} << 32 | 64'hDEADBEEF);
    check("longwait_done_pulses", 64'(dones), 64'd1);
    check("longwait_latency", 64'(lat), 64'd22);
    check("longwait_mem_req_cycles", 64'(mreq_cycles - mq0), 64'd21);
    check("longwait_writes", 64'(writes - wr0), 64'd1);
    check("longwait_mem_content", 64'(mem[16]), 64'hDEADBEEF);

    // Asynchronous reset while a load is stalled in BUSY_D.
    wait_cfg = 100;
    @(negedge clk);
    d_addr = 32'h20; d_we = 1'b0; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_mem_req", 64'(mem_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_outputs_zero", 64'(|{mem_req, mem_we, mem_addr, mem_wdata, if_done, d_done,
                                           if_err, d_err, if_rdata, d_rdata}), 64'd0);
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dones = 0; n = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (if_done || d_done) dones++;
      if (mem_req) n++;
    end
    check("rst_no_spurious_done", 64'(dones), 64'd0);
    check("rst_no_spurious_mem_req", 64'(n), 64'd0);

    // Fresh fetch after reset proves the FSM is back in IDLE.
    wait_cfg = 0;
    @(negedge clk);
    if_addr = 32'h8; if_req = 1'b1;
    lat = -1; rd = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (if_done) begin
        lat = c;
        rd  = if_rdata;
      end
    end
    @(negedge clk);
    if_req = 1'b0;
    check("post_rst_fetch_latency", 64'(lat), 64'd2);
    check("post_rst_fetch_rdata", 64'(rd), 64'h01400113);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Single-port memory arbiter sharing one unified 32-bit word memory between the CPU's instruction-fetch port and its load/store port. It sits between the 5-stage pipeline and the memory model and serialises accesses with a req/done handshake. Data accesses take priority, subject to a starvation bound for fetch. It also rejects misaligned accesses without touching memory.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `MAX_D_STREAK`, 4, consecutive data grants allowed while a fetch is waiting (range 1–15)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request; held high until `if_done`
- `if_addr`  in  ADDR_W  fetch byte address
- `if_rdata`  out  32  fetched word; valid while `if_done`=1
- `if_done`  out  1  one-cycle completion pulse
- `if_err`  out  1  misaligned fetch; valid with `if_done`
- `d_req`  in  1  load/store request; held high until `d_done`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data byte address
- `d_wdata`  in  32  store data
- `d_rdata`  out  32  load data; valid while `d_done`=1
- `d_done`  out  1  one-cycle completion pulse
- `d_err`  out  1  misaligned data access; valid with `d_done`
- `mem_req`  out  1  memory access active
- `mem_we`  out  1  write strobe
- `mem_addr`  out  ADDR_W  latched byte address
- `mem_wdata`  out  32  latched store data
- `mem_rdata`  in  32  read data; valid when `mem_ready`=1
- `mem_ready`  in  1  access completes this cycle

## Operation
- FSM states:
  - IDLE
  - BUSY_I
  - BUSY_D
  - RESP: one-cycle done pulse
- In IDLE, arbitration picks a requester:
  - Only one request pending: that requester wins.
  - Both pending: data wins unless `streak == MAX_D_STREAK`, then fetch wins.
- `streak` is a 4-bit counter:
  - Increments on a data grant while `if_req`=1.
  - Clears on any fetch grant.
  - Clears in any IDLE cycle with `if_req`=0.
  - Saturates at `MAX_D_STREAK`.
- On a grant, the winner's address, `we` and wdata are latched; the FSM moves to BUSY_x and `mem_req`=1. A fetch is always a read (`mem_we`=0).
- Misaligned grant (addr[1:0] ≠ 0):
  - No memory access; `mem_req` stays 0.
  - Go directly to RESP with `x_err`=1 and `x_rdata`=0.
- In BUSY_x, `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable until a cycle with `mem_ready`=1. On that edge:
  - `mem_rdata` is captured (stores capture 0).
  - `mem_req` drops.
  - The FSM moves to RESP.
- In RESP:
  - `x_done`=1 for exactly one cycle.
  - Then IDLE. No arbitration happens in RESP.
- Requests dropped before `done` are a protocol violation. Behaviour is undefined, but the FSM must still return to IDLE once `mem_ready` arrives.
- Stores write memory only through `mem_we` while `mem_req`=1. The arbiter never writes twice for one request.

## Timing
- Reset values, all outputs 0:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`
  - `if_done`, `d_done`, `if_err`, `d_err`
  - `if_rdata`, `d_rdata`
- Reset also sets state = IDLE and `streak` = 0.
- Reset mid-access aborts the access. The requester re-issues after reset.
- All outputs are registered. No combinational path from inputs to outputs.
- Cycle numbering: request first seen high in IDLE at edge E0.
  - `mem_req`=1 from E0 to E0+1+W, where W = cycles with `mem_ready`=0.
  - `x_done` high during cycle E0+2+W.
- Latency figures:
  - Minimum request-to-done is 2 cycles (`mem_ready` tied high).
  - Misaligned request-to-done is 1 cycle.
- Back-to-back throughput: one access per 3 cycles plus wait states (IDLE → BUSY → RESP).
- Simultaneous new requests arriving during BUSY or RESP are ignored until the next IDLE.

## Structure
- Shared package `mem_arb_pkg`:
  - FSM state enum (IDLE, BUSY_I, BUSY_D, RESP).
  - Requester id constants `REQ_I`, `REQ_D`.
  - `WORD_BYTES`=4.
- One natural sub-module, `arb_prio_select`. It is pure combinational: inputs `if_req`, `d_req`, `streak`; outputs `grant_i`, `grant_d`. It is reused later for the DMA port.
- Target 150–250 lines RTL total.

## Test plan
- Reset: assert `rst` mid BUSY_D with `mem_ready`=0. All outputs go 0 immediately (async). After release, FSM is in IDLE and no spurious `done`.
- Fetch only, `mem_ready`=1, `if_addr`=0x8, `mem_rdata`=0x01400113:
  - `mem_req` high for 1 cycle with `mem_addr`=0x8.
  - `if_done` 2 cycles after request, with `if_rdata`=0x01400113.
- Store then load, 2 wait states:
  - Store `d_we`=1, `d_addr`=0, `d_wdata`=30: one write of 30 to address 0; `d_done` at cycle 4.
  - Load from address 0: `d_rdata`=30.
- Contention with `MAX_D_STREAK`=4, `if_req` and `d_req` held continuously: grant order is D,D,D,D,I,D,D,D,D,I…; `streak` never exceeds 4.
- Misaligned access:
  - `d_addr`=0x6 gives `d_done`=`d_err`=1 next cycle with `d_rdata`=0, and `mem_req` never asserts.
  - `if_addr`=0x2 gives `if_err`=1 the same way.
- Long wait: `mem_ready` low for 20 cycles. `mem_addr`, `mem_we` and `mem_wdata` stay stable throughout; exactly one `done` pulse follows.
